// File: rtl/pattern_scan_arbiter.sv
// pattern_scan_arbiter
//   Purpose : shares one serial pattern detector between NREQ byte requesters.
//             An arbiter grants one requester in IDLE, its byte is shifted
//             MSB-first through a PLEN-bit history (one bit per clk), and
//             overlapping PATTERN hits are counted and reported with a
//             1-cycle done pulse tagged by requester id.
//   Latency : gnt in cycle T, done in T+9; one byte per 10 cycles at best.
//   Backpressure: requesters hold req/data until gnt; req is ignored while
//             busy (SCAN/REPORT), so waiting requesters simply stall.
//   Ports   : clk, reset (async, active-high)
//             req[NREQ], data[NREQ*8]    requester side
//             gnt[NREQ] (1-cycle one-hot), busy
//             match (Moore hit flag), done (1-cycle), done_id, match_cnt[4]
//   Config  : define PSA_FIXED_PRIORITY_EN for fixed priority (lowest index
//             wins, no round-robin pointer); default is round-robin.
module pattern_scan_arbiter #(
  parameter int             NREQ    = 4,
  parameter int             PLEN    = 2,
  parameter logic [PLEN-1:0] PATTERN = 2'b01,
  localparam int            IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              match,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [3:0]        match_cnt
);

  // Only PLEN-1 past bits are needed; the incoming bit completes the window.
  localparam int HW = (PLEN > 1) ? PLEN - 1 : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_REPORT
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [7:0]     r_byte;
  logic [IDW-1:0] r_id;
  logic [HW-1:0]  r_hist;
  logic [2:0]     r_bit_cnt;
  logic [3:0]     r_count;
  logic           r_match;
  logic [IDW-1:0] r_done_id;
  logic [3:0]     r_match_cnt;

  logic           w_any;
  logic [IDW-1:0] w_win;
  logic           w_bit;
  logic [PLEN-1:0] w_hist_nxt;
  logic           w_hit;
  logic [3:0]     w_count_nxt;

  // A request can only be taken out of reset, so gnt stays 0 while reset is
  // held even if requesters keep req asserted.
  assign w_any = (|req) & ~reset;

`ifdef PSA_FIXED_PRIORITY_EN
  // Lowest asserted index wins: scanning downward lets the lowest overwrite.
  always_comb begin : p_arb
    w_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) w_win = i[IDW-1:0];
    end
  end
`else
  logic [IDW-1:0] r_ptr;

  // Search starts one past the last winner and wraps, so the last winner
  // has the lowest priority next time.
  always_comb begin : p_arb
    int  idx;
    logic found;
    w_win = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!found && req[idx[IDW-1:0]]) begin
        found = 1'b1;
        w_win = idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= IDW'(NREQ - 1);
    end else if (r_state == S_IDLE && w_any) begin
      r_ptr <= w_win;
    end
  end
`endif

  // Serial datapath: the current bit is always the MSB of the shift register.
  assign w_bit = r_byte[7];

  generate
    if (PLEN == 1) begin : g_hist1
      assign w_hist_nxt = w_bit;
    end else begin : g_histn
      assign w_hist_nxt = {r_hist[PLEN-2:0], w_bit};
    end
  endgenerate

  // The bit_cnt guard stops a hit on a window that still holds cleared
  // (not-yet-shifted) history bits, e.g. PATTERN of all zeros.
  assign w_hit = (r_state == S_SCAN) && (w_hist_nxt == PATTERN) &&
                 (({1'b0, r_bit_cnt} + 4'd1) >= 4'(PLEN));

  assign w_count_nxt = r_count + {3'b000, (w_hit && (r_count != 4'd8))};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    gnt         = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          gnt[w_win]  = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        busy = 1'b1;
        if (r_bit_cnt == 3'd7) w_state_nxt = S_REPORT;
      end
      S_REPORT: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte      <= '0;
      r_id        <= '0;
      r_hist      <= '0;
      r_bit_cnt   <= '0;
      r_count     <= '0;
      r_match     <= 1'b0;
      r_done_id   <= '0;
      r_match_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_match <= 1'b0;
          if (w_any) begin
            r_byte    <= data[{w_win, 3'b000} +: 8];
            r_id      <= w_win;
            r_hist    <= '0;
            r_bit_cnt <= '0;
            r_count   <= '0;
          end
        end
        S_SCAN: begin
          r_byte    <= {r_byte[6:0], 1'b0};
          r_hist    <= w_hist_nxt[HW-1:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_count   <= w_count_nxt;
          r_match   <= w_hit;
          // Results land on the edge into REPORT so they are valid with done.
          if (r_bit_cnt == 3'd7) begin
            r_match_cnt <= w_count_nxt;
            r_done_id   <= r_id;
          end
        end
        S_REPORT: begin
          r_match <= 1'b0;
        end
        default: r_match <= 1'b0;
      endcase
    end
  end

  assign match     = r_match;
  assign done_id   = r_done_id;
  assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
module tb_pattern_scan_arbiter;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  gnt;
  logic        busy, match, done;
  logic [1:0]  done_id;
  logic [3:0]  match_cnt;

  logic [3:0]  req3 = '0;
  logic [31:0] data3 = '0;
  logic [3:0]  gnt3;
  logic        busy3, match3, done3;
  logic [1:0]  done_id3;
  logic [3:0]  match_cnt3;

  int n_tests = 0;
  int n_fail  = 0;
  int rr_ptr  = NREQ - 1;
  int last_id = 0;
  int last_cnt = 0;

  pattern_scan_arbiter #(.NREQ(4), .PLEN(2), .PATTERN(2'b01)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .match(match), .done(done), .done_id(done_id), .match_cnt(match_cnt)
  );

  pattern_scan_arbiter #(.NREQ(4), .PLEN(3), .PATTERN(3'b111)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .data(data3), .gnt(gnt3), .busy(busy3),
    .match(match3), .done(done3), .done_id(done_id3), .match_cnt(match_cnt3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Hit after shifting bit s (0 = byte[7]): the last plen bits shifted are
  // byte[7-s+plen-1 : 7-s], oldest bit in the most significant position.
  function automatic int hit_at(input int b, input int s, input int plen, input int pat);
    if (s < 0 || s + 1 < plen) return 0;
    return (((b >> (7 - s)) & ((1 << plen) - 1)) == pat) ? 1 : 0;
  endfunction

  function automatic int hits(input int b, input int plen, input int pat);
    int n = 0;
    for (int s = 0; s < 8; s++) n += hit_at(b, s, plen, pat);
    return n;
  endfunction

  function automatic int pick(input int m);
`ifdef PSA_FIXED_PRIORITY_EN
    for (int i = 0; i < NREQ; i++) if (((m >> i) & 1) != 0) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (((m >> ((rr_ptr + k) % NREQ)) & 1) != 0) return (rr_ptr + k) % NREQ;
`endif
    return -1;
  endfunction

  // One byte through dut. mode 0: winner drops req; 1: req held;
  // 2: random req/data while busy; 3: requester 1 waits while busy.
  task automatic txn(input logic [3:0] m, input logic [31:0] d, input int mode);
    int w, b, total, em;
    @(posedge clk); #1;
    req = m; data = d;
    #1;
    w = pick(int'(m));
    chk("gnt", int'(gnt), 1 << w);
    chk("busy_idle", int'(busy), 0);
    chk("done_idle", int'(done), 0);
    rr_ptr = w;
    b = int'((d >> (8 * w)) & 32'hFF);
    total = hits(b, 2, 1);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      case (mode)
        0: req = m & ~(4'b0001 << w);
        1: req = m;
        2: begin req = 4'($urandom); data = $urandom; end
        default: req = 4'b0010;
      endcase
      #1;
      em = (k >= 2) ? hit_at(b, k - 2, 2, 1) : 0;
      chk("gnt_busy", int'(gnt), 0);
      chk("busy", int'(busy), 1);
      chk("match", int'(match), em);
      chk("done", int'(done), (k == 9) ? 1 : 0);
      if (k == 9) begin
        chk("done_id", int'(done_id), w);
        chk("match_cnt", int'(match_cnt), total);
      end
    end
    last_id = w;
    last_cnt = total;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    req = '0;
    #1;
    chk("gnt_noreq", int'(gnt), 0);
    chk("busy_noreq", int'(busy), 0);
    chk("match_noreq", int'(match), 0);
    chk("done_noreq", int'(done), 0);
    chk("cnt_held", int'(match_cnt), last_cnt);
    chk("id_held", int'(done_id), last_id);
  endtask

  task automatic run3(input logic [7:0] b);
    int total;
    @(posedge clk); #1;
    req3 = 4'b0001; data3 = {24'h0, b};
    #1;
    chk("gnt3", int'(gnt3), 1);
    total = hits(int'(b), 3, 7);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      req3 = '0;
      #1;
      chk("busy3", int'(busy3), 1);
      chk("match3", int'(match3), (k >= 2) ? hit_at(int'(b), k - 2, 3, 7) : 0);
      chk("done3", int'(done3), (k == 9) ? 1 : 0);
      if (k == 9) begin
        chk("match_cnt3", int'(match_cnt3), total);
        chk("done_id3", int'(done_id3), 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int m, mode;
    logic [31:0] d;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_match", int'(match), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_match_cnt", int'(match_cnt), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Held 1111: round-robin from index 0, back to back every 10 cycles.
    for (int i = 0; i < 5; i++) txn(4'b1111, $urandom, 1);
    idle_cycle();

    // Directed bytes on requester 0, including all-ones and all-zeros.
    txn(4'b0001, 32'h0000_0055, 0);
    txn(4'b0001, 32'h0000_000F, 0);
    txn(4'b0001, 32'h0000_00FF, 0);
    txn(4'b0001, 32'h0000_0000, 0);
    txn(4'b0001, 32'h0000_0001, 0);
    txn(4'b0001, 32'h0000_0080, 0);
    idle_cycle();

    // Requester 1 waits during a scan, then drops while requester 2 asks.
    txn(4'b0001, 32'h0000_00A5, 3);
    txn(4'b0100, 32'h00C3_0000, 0);
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      m = $urandom_range(1, 15);
      mode = $urandom_range(0, 2);
      d = $urandom;
      txn(4'(m), d, mode);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    // Reset in the middle of SCAN aborts the byte.
    @(posedge clk); #1;
    req = 4'b0001; data = 32'h0000_00AA;
    #1;
    chk("gnt_pre_rst", int'(gnt), 1 << pick(1));
    rr_ptr = pick(1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      req = '0;
      #1;
      chk("busy_pre_rst", int'(busy), 1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", int'(gnt), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_match", int'(match), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_done_id", int'(done_id), 0);
    chk("mid_rst_match_cnt", int'(match_cnt), 0);
    rr_ptr = NREQ - 1;
    last_id = 0;
    last_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) idle_cycle();
    txn(4'b1000, 32'h5A00_0000, 0);
    txn(4'b1001, 32'h0000_0033, 0);

    // PLEN=3, PATTERN=111 instance.
    run3(8'hFF);
    run3(8'hEF);
    run3(8'h00);
    run3(8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
